apb_master: RTL
===============

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 32, APB address width.
REQ-002 Parameter DATA_W, default 32, APB data width.
REQ-003 Parameter TIMEOUT, default 16, max ACCESS cycles without pready; 0 disables timeout.
REQ-004 One clock, i_clk_apb; reset i_rstn_apb is asynchronous, active-low.
REQ-005 Ports (name  direction  width  meaning) SHALL be:
i_clk_apb  in  1  APB clock
i_rstn_apb  in  1  async active-low reset
i_cmd_valid  in  1  command request
o_cmd_ready  out  1  command accepted this cycle
i_cmd_addr  in  ADDR_W  command address
i_cmd_rd0_wr1  in  1  0=read, 1=write
i_cmd_wdata  in  DATA_W  write data
o_psel  out  1  APB select
o_penable  out  1  APB enable
o_paddr  out  ADDR_W  APB address
o_pwrite  out  1  APB direction
o_pwdata  out  DATA_W  APB write data
i_pready  in  1  slave ready
i_prdata  in  DATA_W  slave read data
i_pslverr  in  1  slave error
o_rsp_valid  out  1  response available
i_rsp_ready  in  1  response consumed
o_rsp_rdata  out  DATA_W  read data (0 for writes/errors)
o_rsp_err  out  1  pslverr or timeout
o_rsp_timeout  out  1  transfer aborted by timeout

Function
REQ-006 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; all APB and response outputs registered.
REQ-007 o_cmd_ready SHALL be 1 only in IDLE; handshake = i_cmd_valid & o_cmd_ready.
REQ-008 On handshake: capture addr/dir/wdata into o_paddr/o_pwrite/o_pwdata, go SETUP next cycle.
REQ-009 SETUP: psel=1, penable=0, exactly one cycle, then ACCESS.
REQ-010 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata stable from SETUP until exit.
REQ-011 ACCESS with i_pready=1: latch o_rsp_rdata=i_prdata if read (0 if write or i_pslverr=1), o_rsp_err=i_pslverr, o_rsp_timeout=0; next state RESP, psel/penable=0.
REQ-012 Wait counter SHALL clear on SETUP entry, increment each ACCESS cycle with i_pready=0, saturate.
REQ-013 TIMEOUT>0 and counter reaches TIMEOUT-1 with i_pready=0: abort, psel/penable=0, o_rsp_err=1, o_rsp_timeout=1, rdata=0, go RESP.
REQ-014 i_pready=1 on the timeout cycle SHALL win (normal completion).
REQ-015 RESP: o_rsp_valid=1, fields stable until i_rsp_ready=1; then IDLE next cycle, o_rsp_valid=0.
REQ-016 Minimum transfer: handshake cycle + SETUP + ACCESS + RESP = 4 cycles command-to-command with zero wait states and i_rsp_ready=1.
REQ-017 i_pready/i_prdata/i_pslverr SHALL be ignored outside ACCESS.
REQ-018 In IDLE, o_paddr/o_pwrite/o_pwdata hold last transfer values; psel=penable=0.

Reset
REQ-019 Asserting i_rstn_apb=0 SHALL immediately force state IDLE and all outputs 0 (except o_cmd_ready=1 after deassertion), aborting any transfer without a response.
REQ-020 First command accepted on the first rising edge after deassertion.

Structure
REQ-021 apb_pkg SHALL hold the state enum apb_mst_state_t and default ADDR_W/DATA_W constants; apb_slave state enum may share it.
REQ-022 One sub-module apb_wait_timer (clear, enable, saturating count, expired flag) SHALL implement REQ-012/013.

Verification
REQ-023 Write 0x0000_0010 data 0xDEAD_BEEF, pready=1 in first ACCESS -> SETUP 1 cycle, ACCESS 1 cycle, rsp_err=0, rdata=0.
REQ-024 Read 0x0000_0020, pready after 3 wait cycles, prdata=0x1234_5678 -> ACCESS 4 cycles, paddr stable, rsp_rdata=0x1234_5678.
REQ-025 Read with pslverr=1 at pready -> rsp_err=1, rsp_timeout=0, rdata=0.
REQ-026 TIMEOUT=16, pready held 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1; pready=1 on cycle 16 -> normal completion.
REQ-027 i_rsp_ready held 0 for 5 cycles -> rsp fields stable, o_cmd_ready=0; reset asserted mid-ACCESS -> psel/penable=0 same cycle, no response.
REQ-028 Integrated with apb_slave (i_ready=1, i_rd_valid=1) -> back-to-back write/read of 0x0000_0004 completes with rsp_err=0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master/slave blocks.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_mst_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; flags when the ACCESS phase has used up its budget.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] count;

  // Count stalled ACCESS cycles, parking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

  // TIMEOUT of zero means the master waits forever.
  assign expired = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: command in, one APB transfer, one response out.
module apb_master
  import apb_pkg::*;
#(
  parameter int          ADDR_W  = APB_ADDR_W,
  parameter int          DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              i_clk_apb,
  input  logic              i_rstn_apb,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic              i_cmd_rd0_wr1,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_psel,
  output logic              o_penable,
  output logic [ADDR_W-1:0] o_paddr,
  output logic              o_pwrite,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic              i_pready,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pslverr,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_rsp_timeout
);

  apb_mst_state_t    state, state_nxt;
  logic              psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt, rsp_rdata_nxt;
  logic              rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic              timer_clear, timer_en, timer_expired;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (i_clk_apb),
    .rst_n   (i_rstn_apb),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // Ready is gated by reset so it reads 0 while held in reset and 1 on the first cycle out.
  assign o_cmd_ready = (state == ST_IDLE) && i_rstn_apb;

  // State and every APB/response output are registered; reset drops them all at once.
  always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
    if (!i_rstn_apb) begin
      state         <= ST_IDLE;
      o_psel        <= 1'b0;
      o_penable     <= 1'b0;
      o_paddr       <= '0;
      o_pwrite      <= 1'b0;
      o_pwdata      <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;
    end else begin
      state         <= state_nxt;
      o_psel        <= psel_nxt;
      o_penable     <= penable_nxt;
      o_paddr       <= paddr_nxt;
      o_pwrite      <= pwrite_nxt;
      o_pwdata      <= pwdata_nxt;
      o_rsp_valid   <= rsp_valid_nxt;
      o_rsp_rdata   <= rsp_rdata_nxt;
      o_rsp_err     <= rsp_err_nxt;
      o_rsp_timeout <= rsp_timeout_nxt;
    end
  end

  // Next-state and next-output decode; everything holds unless a phase changes it.
  always_comb begin
    state_nxt       = state;
    psel_nxt        = o_psel;
    penable_nxt     = o_penable;
    paddr_nxt       = o_paddr;
    pwrite_nxt      = o_pwrite;
    pwdata_nxt      = o_pwdata;
    rsp_valid_nxt   = o_rsp_valid;
    rsp_rdata_nxt   = o_rsp_rdata;
    rsp_err_nxt     = o_rsp_err;
    rsp_timeout_nxt = o_rsp_timeout;
    timer_clear     = 1'b0;
    timer_en        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          paddr_nxt   = i_cmd_addr;
          pwrite_nxt  = i_cmd_rd0_wr1;
          pwdata_nxt  = i_cmd_wdata;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          timer_clear = 1'b1;
          state_nxt   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A ready slave beats the timeout on the same cycle.
        if (i_pready) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = (!o_pwrite && !i_pslverr) ? i_prdata : '0;
          rsp_err_nxt     = i_pslverr;
          rsp_timeout_nxt = 1'b0;
          state_nxt       = ST_RESP;
        end else if (timer_expired) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = '0;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          state_nxt       = ST_RESP;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
